// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32 MEM stage: data-memory handshake, stall, branch resolve, MEM/WB register; optional MEM_STAGE_TIMEOUT_EN
package cpu_pkg;
    typedef struct packed {
        logic [31:0] branch_adder_sum;
        logic [31:0] ALU_result;
        logic [31:0] reg_read_data2;
        logic [4:0]  rd;
    } ex_mem_data_t;

    typedef struct packed {
        logic WB_reg_write;
        logic WB_mem_to_reg;
        logic M_branch;
        logic M_mem_read;
        logic M_mem_write;
        logic ALU_zero;
    } ex_mem_control_t;
endpackage

module mem_stage #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  cpu_pkg::ex_mem_data_t    data_in,
    input  cpu_pkg::ex_mem_control_t control_in,
    output logic                     stall,
    output logic                     pc_src,
    output logic [31:0]              branch_target,
    output logic                     dmem_req,
    output logic                     dmem_we,
    output logic [31:0]              dmem_addr,
    output logic [31:0]              dmem_wdata,
    input  logic [31:0]              dmem_rdata,
    input  logic                     dmem_ready,
    output logic                     wb_valid,
    output logic                     wb_reg_write,
    output logic                     wb_mem_to_reg,
    output logic [31:0]              wb_read_data,
    output logic [31:0]              wb_alu_result,
    output logic [4:0]               wb_rd,
    output logic                     mem_fault
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t state, state_next;
    logic   mem_op;
    logic   req_c;
    logic   stall_c;
    logic   abort;
    logic   is_load;

    assign mem_op  = control_in.M_mem_read | control_in.M_mem_write;
    assign is_load = control_in.M_mem_read & ~control_in.M_mem_write;

`ifdef MEM_STAGE_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] wait_cnt;

    // A ready arriving in the last allowed cycle still completes the access.
    assign abort = (state == S_WAIT) && (wait_cnt == CNT_LAST) && !dmem_ready;

    always_ff @(posedge clock) begin
        if (reset || state != S_WAIT) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + CW'(1);
        end
        mem_fault <= reset ? 1'b0 : abort;
    end
`else
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYCLES != 0);
    assign abort          = 1'b0;
    assign mem_fault      = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_op) begin
                    req_c = 1'b1;
                    if (!dmem_ready) begin
                        stall_c    = 1'b1;
                        state_next = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (dmem_ready) begin
                    req_c      = 1'b1;
                    state_next = S_IDLE;
                end else if (abort) begin
                    state_next = S_IDLE;
                end else begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (reset) begin
            req_c   = 1'b0;
            stall_c = 1'b0;
        end
    end

    assign stall         = stall_c;
    assign dmem_req      = req_c;
    assign dmem_we       = req_c & control_in.M_mem_write;
    assign dmem_addr     = data_in.ALU_result;
    assign dmem_wdata    = data_in.reg_read_data2;
    assign pc_src        = ~reset & control_in.M_branch & control_in.ALU_zero;
    assign branch_target = data_in.branch_adder_sum;

    // Stalled cycles push a bubble so the held instruction is written back once.
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
            wb_read_data  <= '0;
            wb_alu_result <= '0;
            wb_rd         <= '0;
        end else if (stall_c) begin
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_mem_to_reg <= 1'b0;
        end else begin
            wb_valid      <= |control_in;
            wb_reg_write  <= control_in.WB_reg_write & ~control_in.M_mem_write & ~abort;
            wb_mem_to_reg <= control_in.WB_mem_to_reg;
            wb_alu_result <= data_in.ALU_result;
            wb_rd         <= data_in.rd;
            if (req_c && dmem_ready && is_load) begin
                wb_read_data <= dmem_rdata;
            end
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - directed self-checking bench for mem_stage
module tb_mem_stage;
    logic                     clock;
    logic                     reset;
    cpu_pkg::ex_mem_data_t    d;
    cpu_pkg::ex_mem_control_t c;
    logic                     stall, pc_src, dmem_req, dmem_we, dmem_ready;
    logic [31:0]              branch_target, dmem_addr, dmem_wdata, dmem_rdata;
    logic                     wb_valid, wb_reg_write, wb_mem_to_reg, mem_fault;
    logic [31:0]              wb_read_data, wb_alu_result;
    logic [4:0]               wb_rd;
    int                       checks = 0;
    int                       errors = 0;

    mem_stage #(.TIMEOUT_CYCLES(4)) dut (
        .clock(clock), .reset(reset), .data_in(d), .control_in(c),
        .stall(stall), .pc_src(pc_src), .branch_target(branch_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ready(dmem_ready),
        .wb_valid(wb_valid), .wb_reg_write(wb_reg_write), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_read_data(wb_read_data), .wb_alu_result(wb_alu_result), .wb_rd(wb_rd),
        .mem_fault(mem_fault)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic bubble();
        c = '0;
        d = '0;
        dmem_ready = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        d.branch_adder_sum = 32'h55; d.ALU_result = 32'h99; d.rd = 5'd7;
        c = '1;
        dmem_ready = 1'b1; dmem_rdata = 32'h1234;
        tick(); tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b want 0", wb_valid); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL reset_wb_reg_write got %b want 0", wb_reg_write); end
        checks++; if (wb_mem_to_reg !== 1'b0) begin errors++; $display("FAIL reset_wb_mem_to_reg got %b want 0", wb_mem_to_reg); end
        checks++; if (wb_read_data !== 32'h0) begin errors++; $display("FAIL reset_wb_read_data got %h want 0", wb_read_data); end
        checks++; if (wb_alu_result !== 32'h0) begin errors++; $display("FAIL reset_wb_alu_result got %h want 0", wb_alu_result); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL reset_wb_rd got %0d want 0", wb_rd); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL reset_dmem_req got %b want 0", dmem_req); end
        checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL reset_pc_src got %b want 0", pc_src); end
        checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL reset_mem_fault got %b want 0", mem_fault); end
        reset = 1'b0;
        bubble();
        tick();
    endtask

    task automatic test_rtype();
        bubble();
        d.ALU_result = 32'd12345; d.rd = 5'd31; c.WB_reg_write = 1'b1;
        @(negedge clock);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rtype_stall got %b want 0", stall); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rtype_req got %b want 0", dmem_req); end
        tick();
        checks++; if (wb_alu_result !== 32'd12345) begin errors++; $display("FAIL rtype_alu got %0d want 12345", wb_alu_result); end
        checks++; if (wb_rd !== 5'd31) begin errors++; $display("FAIL rtype_rd got %0d want 31", wb_rd); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL rtype_valid got %b want 1", wb_valid); end
        checks++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL rtype_reg_write got %b want 1", wb_reg_write); end
        bubble();
    endtask

    task automatic test_load_wait();
        bubble();
        c.M_mem_read = 1'b1; c.WB_mem_to_reg = 1'b1; c.WB_reg_write = 1'b1;
        d.ALU_result = 32'h100; d.rd = 5'd5; dmem_rdata = 32'hBAD;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL load_stall[%0d] got %b want 1", i, stall); end
            checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL load_req[%0d] got %b want 1", i, dmem_req); end
            checks++; if (dmem_addr !== 32'h100) begin errors++; $display("FAIL load_addr[%0d] got %h want 100", i, dmem_addr); end
            checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL load_we[%0d] got %b want 0", i, dmem_we); end
            tick();
            checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL load_bubble[%0d] got %b want 0", i, wb_valid); end
        end
        dmem_ready = 1'b1; dmem_rdata = 32'd4321;
        @(negedge clock);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL load_done_stall got %b want 0", stall); end
        tick();
        checks++; if (wb_read_data !== 32'd4321) begin errors++; $display("FAIL load_rdata got %0d want 4321", wb_read_data); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL load_valid got %b want 1", wb_valid); end
        checks++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL load_reg_write got %b want 1", wb_reg_write); end
        checks++; if (wb_mem_to_reg !== 1'b1) begin errors++; $display("FAIL load_mem_to_reg got %b want 1", wb_mem_to_reg); end
        checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL load_rd got %0d want 5", wb_rd); end
        bubble();
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL load_once got %b want 0", wb_valid); end
    endtask

    task automatic test_store();
        bubble();
        c.M_mem_write = 1'b1; c.WB_reg_write = 1'b1;
        d.reg_read_data2 = 32'hDEADBEEF; d.ALU_result = 32'h200;
        dmem_ready = 1'b1; dmem_rdata = 32'h77;
        @(negedge clock);
        checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL store_we got %b want 1", dmem_we); end
        checks++; if (dmem_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL store_wdata got %h want deadbeef", dmem_wdata); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL store_stall got %b want 0", stall); end
        tick();
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL store_valid got %b want 1", wb_valid); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL store_reg_write got %b want 0", wb_reg_write); end
        checks++; if (wb_read_data !== 32'd4321) begin errors++; $display("FAIL store_rdata_hold got %0d want 4321", wb_read_data); end
        c.M_mem_read = 1'b1;
        @(negedge clock);
        checks++; if (dmem_we !== 1'b1) begin errors++; $display("FAIL rw_priority_we got %b want 1", dmem_we); end
        tick();
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL rw_reg_write got %b want 0", wb_reg_write); end
        checks++; if (wb_read_data !== 32'd4321) begin errors++; $display("FAIL rw_rdata_hold got %0d want 4321", wb_read_data); end
        bubble();
        dmem_ready = 1'b1; dmem_rdata = 32'h99;
        tick();
        checks++; if (wb_read_data !== 32'd4321) begin errors++; $display("FAIL ready_no_req got %0d want 4321", wb_read_data); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %b want 0", wb_valid); end
        bubble();
    endtask

    task automatic test_branch();
        bubble();
        c.M_branch = 1'b1; c.ALU_zero = 1'b1; d.branch_adder_sum = 32'd1234;
        @(negedge clock);
        checks++; if (pc_src !== 1'b1) begin errors++; $display("FAIL branch_taken got %b want 1", pc_src); end
        checks++; if (branch_target !== 32'd1234) begin errors++; $display("FAIL branch_target got %0d want 1234", branch_target); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL branch_req got %b want 0", dmem_req); end
        c.ALU_zero = 1'b0;
        @(negedge clock);
        checks++; if (pc_src !== 1'b0) begin errors++; $display("FAIL branch_not_taken got %b want 0", pc_src); end
        tick();
        bubble();
    endtask

    task automatic test_back_to_back();
        bubble();
        c.M_mem_read = 1'b1; c.WB_reg_write = 1'b1; d.ALU_result = 32'h10; d.rd = 5'd1;
        tick();
        dmem_ready = 1'b1; dmem_rdata = 32'd11;
        tick();
        checks++; if (wb_read_data !== 32'd11) begin errors++; $display("FAIL b2b_first got %0d want 11", wb_read_data); end
        d.ALU_result = 32'h20; d.rd = 5'd2; dmem_rdata = 32'd22;
        @(negedge clock);
        checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL b2b_req got %b want 1", dmem_req); end
        checks++; if (dmem_addr !== 32'h20) begin errors++; $display("FAIL b2b_addr got %h want 20", dmem_addr); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %b want 0", stall); end
        tick();
        checks++; if (wb_read_data !== 32'd22) begin errors++; $display("FAIL b2b_second got %0d want 22", wb_read_data); end
        checks++; if (wb_rd !== 5'd2) begin errors++; $display("FAIL b2b_rd got %0d want 2", wb_rd); end
        bubble();
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bubble();
        c.M_mem_read = 1'b1; c.WB_reg_write = 1'b1; d.ALU_result = 32'h40; d.rd = 5'd9;
        tick();
        tick();
        reset = 1'b1;
        @(negedge clock);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_wait_stall got %b want 0", stall); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_wait_req got %b want 0", dmem_req); end
        tick();
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wait_valid got %b want 0", wb_valid); end
        checks++; if (wb_rd !== 5'd0) begin errors++; $display("FAIL rst_wait_rd got %0d want 0", wb_rd); end
        reset = 1'b0;
        bubble();
        @(negedge clock);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rst_wait_idle_stall got %b want 0", stall); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL rst_wait_idle_req got %b want 0", dmem_req); end
        tick();
        checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL rst_wait_fault got %b want 0", mem_fault); end
    endtask

`ifdef MEM_STAGE_TIMEOUT_EN
    task automatic test_timeout();
        bubble();
        c.M_mem_read = 1'b1; c.WB_reg_write = 1'b1; d.ALU_result = 32'h80; d.rd = 5'd3;
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL to_stall[%0d] got %b want 1", i, stall); end
            checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL to_early_fault[%0d] got %b want 0", i, mem_fault); end
            tick();
        end
        @(negedge clock);
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL to_abort_stall got %b want 0", stall); end
        checks++; if (dmem_req !== 1'b0) begin errors++; $display("FAIL to_abort_req got %b want 0", dmem_req); end
        tick();
        checks++; if (mem_fault !== 1'b1) begin errors++; $display("FAIL to_fault got %b want 1", mem_fault); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL to_valid got %b want 1", wb_valid); end
        checks++; if (wb_reg_write !== 1'b0) begin errors++; $display("FAIL to_reg_write got %b want 0", wb_reg_write); end
        bubble();
        tick();
        checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL to_fault_pulse got %b want 0", mem_fault); end
    endtask
`else
    task automatic test_no_timeout();
        bubble();
        c.M_mem_read = 1'b1; c.WB_reg_write = 1'b1; d.ALU_result = 32'h80; d.rd = 5'd3;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock);
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL nto_stall[%0d] got %b want 1", i, stall); end
            checks++; if (mem_fault !== 1'b0) begin errors++; $display("FAIL nto_fault[%0d] got %b want 0", i, mem_fault); end
            tick();
        end
        dmem_ready = 1'b1; dmem_rdata = 32'h5A5A;
        tick();
        checks++; if (wb_read_data !== 32'h5A5A) begin errors++; $display("FAIL nto_rdata got %h want 5a5a", wb_read_data); end
        checks++; if (wb_reg_write !== 1'b1) begin errors++; $display("FAIL nto_reg_write got %b want 1", wb_reg_write); end
        bubble();
        tick();
    endtask
`endif

    initial begin
        reset = 1'b1;
        bubble();
        test_reset();
        test_rtype();
        test_load_wait();
        test_store();
        test_branch();
        test_back_to_back();
`ifdef MEM_STAGE_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV32 pipeline: the consumer end of the EX/MEM pipeline register. It takes the EX/MEM data and control bundles, drives a single-port data-memory request/ready bus, and stalls the front of the pipeline while an access is outstanding. It resolves the branch decision (PCSrc) and registers the MEM/WB bundle for write-back.

## Interface
- `TIMEOUT_CYCLES`, default 16: WAIT cycles allowed before an access is aborted. Only used with `MEM_STAGE_TIMEOUT_EN`.
- `clock`  in  1  rising-edge clock
- `reset`  in  1  synchronous, active-high reset
- `data_in`  in  `cpu_pkg::ex_mem_data_t`  fields: `branch_adder_sum[31:0]`, `ALU_result[31:0]`, `reg_read_data2[31:0]`, `rd[4:0]`
- `control_in`  in  `cpu_pkg::ex_mem_control_t`  fields: `WB_reg_write`, `WB_mem_to_reg`, `M_branch`, `M_mem_read`, `M_mem_write`, `ALU_zero`
- `stall`  out  1  hold EX/MEM and all upstream stages this cycle
- `pc_src`  out  1  take branch (`M_branch & ALU_zero`)
- `branch_target`  out  32  equals `data_in.branch_adder_sum`
- `dmem_req`, `dmem_we`  out  1 each  access request; write enable
- `dmem_addr`, `dmem_wdata`  out  32 each  `ALU_result`; `reg_read_data2`
- `dmem_rdata`  in  32  read data, valid when `dmem_ready`=1
- `dmem_ready`  in  1  access completes this cycle
- `wb_valid`, `wb_reg_write`, `wb_mem_to_reg`  out  1 each  registered MEM/WB control
- `wb_read_data`, `wb_alu_result`  out  32 each  registered MEM/WB data
- `wb_rd`  out  5  registered destination register
- `mem_fault`  out  1  one-cycle abort pulse (0 when the timeout feature is compiled out)

## Operation
- Memory op: `M_mem_read | M_mem_write`. When both are set, the write has priority. The access is a store, and `wb_reg_write` is forced to 0.
- A bubble is all-zero control. It produces `wb_valid`=0 and `wb_reg_write`=0.
- FSM states:
  - IDLE: on a memory op, assert `dmem_req` combinationally, with `dmem_we`=`M_mem_write`.
    - If `dmem_ready`=1 in the same cycle: zero-wait access. `stall`=0, MEM/WB captures at the edge, stay in IDLE.
    - Otherwise: `stall`=1 and go to WAIT.
  - WAIT: `dmem_req`=1 and `stall`=1. Upstream holds `data_in`/`control_in` stable.
    - On `dmem_ready`=1: `stall`=0 that cycle, MEM/WB captures (`wb_read_data`=`dmem_rdata` for loads), go to IDLE.
- A non-memory instruction in IDLE passes to MEM/WB in 1 cycle with `stall`=0. `wb_read_data` holds its previous value.
- While `stall`=1, each edge loads a bubble into MEM/WB. The stalled instruction is not duplicated.
- `pc_src` and `branch_target` are combinational from the inputs and independent of the FSM. Branches never access memory.
- A store sets `wb_valid`=1 and `wb_reg_write`=0.

## Timing
- Reset, on the edge where `reset`=1:
  - state IDLE, timeout counter 0, `mem_fault`=0.
  - All `wb_*` outputs are 0.
- While `reset`=1, `dmem_req`, `stall` and `pc_src` are gated to 0.
- Reset mid-WAIT abandons the access, with no MEM/WB capture. The memory must tolerate a dropped request.
- Latency:
  - non-memory instruction or zero-wait access: 1 cycle to MEM/WB.
  - access with N wait cycles: N+1 cycles.
  - back-to-back accesses: the second request can be issued in the cycle after the first completes.
- `dmem_addr`, `dmem_wdata` and `dmem_we` stay stable while `dmem_req`=1.
- `dmem_rdata` is sampled only in a cycle where `dmem_ready`=1 and `dmem_req`=1. `dmem_ready` with `dmem_req`=0 is ignored.

## Configuration
- `MEM_STAGE_TIMEOUT_EN` defined:
  - A counter increments each cycle in WAIT. It is cleared in IDLE.
  - In the cycle the counter equals `TIMEOUT_CYCLES`-1 with no ready:
    - `dmem_req`=0 and `stall`=0.
    - MEM/WB captures the instruction with `wb_reg_write`=0 and `wb_valid`=1.
    - `mem_fault` pulses for 1 cycle (registered) and the FSM goes to IDLE.
  - A ready in that same cycle wins over the timeout.
- Undefined: WAIT lasts indefinitely, the counter is absent, and `mem_fault` is tied to 0.

## Test plan
- Reset: hold `reset`=1 for 2 cycles with arbitrary inputs -> all `wb_*` outputs, `stall`, `dmem_req`, `pc_src` and `mem_fault` read 0.
- R-type pass-through: `ALU_result`=12345, `rd`=31, `WB_reg_write`=1 -> next cycle `wb_alu_result`=12345, `wb_rd`=31, `wb_valid`=1, `stall` never asserted.
- Load with 3 wait cycles: `M_mem_read`=1, `WB_mem_to_reg`=1, `ALU_result`=0x100, `dmem_rdata`=4321 on the 4th cycle -> `stall`=1 for 3 cycles and `dmem_addr`=0x100 throughout; then `wb_read_data`=4321, 3 bubble cycles before it.
- Zero-wait store: `M_mem_write`=1, `reg_read_data2`=0xDEADBEEF, `dmem_ready`=1 -> `dmem_we`=1, `dmem_wdata`=0xDEADBEEF, `stall`=0; next cycle `wb_valid`=1, `wb_reg_write`=0.
- Branch: `M_branch`=1, `ALU_zero`=1, `branch_adder_sum`=1234 -> `pc_src`=1 and `branch_target`=1234 in the same cycle. With `ALU_zero`=0 -> `pc_src`=0.
- Timeout (macro defined, `TIMEOUT_CYCLES`=4): load with `dmem_ready` held at 0 -> `stall` is high for 4 cycles, then `mem_fault`=1 for exactly one cycle and `wb_reg_write`=0. Also assert `reset` in the 2nd WAIT cycle of a fresh load -> the FSM returns to IDLE with no `wb_valid`.
